onehot_encoder_pipe: RTL and testbench

//   Registered one-hot to binary encoder with valid/ready handshake on both sides.
//   It is the inverse of the team's 2-to-4 one-hot decoder: it maps a one-hot select

---
 rtl/onehot_encoder_pipe.sv | 83 ++++++++
 tb/tb_onehot_encoder_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_pipe.sv
// Registered one-hot to binary encoder with valid/ready handshake on both sides.
// It flags words that are not one-hot and keeps a saturating count of them.
module onehot_encoder_pipe #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_onehot,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N)-1:0]       out_code,
  output logic                       out_err,
  output logic [CNT_W-1:0]           err_count
);

  localparam int unsigned W = $clog2(N);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_code;
  logic             r_err;
  logic [CNT_W-1:0] r_err_count;

  logic             w_accept;
  logic [W-1:0]     w_code;
  logic             w_seen;
  logic             w_multi;
  logic             w_err;

  // Priority encode: the highest set bit wins; track zero and multi-hot words
  always_comb begin
    w_code  = '0;
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_onehot[i]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
        w_code = W'(i);
      end
    end
    w_err = !w_seen || w_multi;
  end

  assign out_valid = (r_state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_code      <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        EMPTY:   if (w_accept) r_state <= FULL;
        FULL:    if (out_ready && !w_accept) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase
      if (w_accept) begin
        r_code <= w_code;
        r_err  <= w_err;
      end
      // Counted at accept time; sticks at all-ones
      if (w_accept && w_err && (r_err_count != {CNT_W{1'b1}})) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign out_code  = r_code;
  assign out_err   = r_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Bench for onehot_encoder_pipe: directed scenarios plus randomized traffic
// compared against a transaction-level model of the output register.
module tb_onehot_encoder_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_onehot;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_code;
  logic       out_err;
  logic [7:0] err_count;

  int checks;
  int failures;

  // Reference model of what the outputs should show
  logic       m_valid;
  logic [1:0] m_code;
  logic       m_err;
  int         m_cnt;
  logic       obs_ready;
  logic       exp_ready;

  onehot_encoder_pipe #(.N(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_onehot (in_onehot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index of highest set bit from arithmetic, 0 for an all-zero word
  function automatic logic [1:0] ref_code(input logic [3:0] w);
    if (w == 4'd0) return 2'd0;
    return 2'($clog2(int'(w) + 1) - 1);
  endfunction

  function automatic logic ref_err(input logic [3:0] w);
    return $countones(w) != 1;
  endfunction

  // Drive one cycle from a negedge, capture in_ready, advance the model, return at next negedge
  task automatic cycle(input logic rst, input logic v, input logic [3:0] w, input logic ordy);
    logic acc;
    rst_n     = rst;
    in_valid  = v;
    in_onehot = w;
    out_ready = ordy;
    #1;
    obs_ready = in_ready;
    exp_ready = !m_valid || ordy;
    @(posedge clk);
    if (!rst) begin
      m_valid = 1'b0;
      m_code  = 2'd0;
      m_err   = 1'b0;
      m_cnt   = 0;
    end else begin
      acc = v && (!m_valid || ordy);
      if (acc) begin
        m_valid = 1'b1;
        m_code  = ref_code(w);
        m_err   = ref_err(w);
        if (m_err && m_cnt < 255) m_cnt++;
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b1, 4'b0001, 1'b1);
    cycle(1'b0, 1'b1, 4'b0001, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || err_count !== 8'd0 || out_code !== 2'd0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b code=%0d err=%b cnt=%0d, required 0 0 0 0",
               out_valid, out_code, out_err, err_count);
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 4'(1 << i), 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_code !== 2'(i) || out_err !== 1'b0 || obs_ready !== 1'b1) begin
        failures++;
        $display("FAIL sweep_%0d: valid=%b code=%0d err=%b ready=%b, required 1 %0d 0 1",
                 i, out_valid, out_code, out_err, obs_ready, i);
      end
    end
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sweep_drain: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 1'b1, 4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 4'b0001, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_code !== 2'd2 || out_err !== 1'b0 || obs_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_%0d: valid=%b code=%0d err=%b ready=%b, required 1 2 0 0",
                 i, out_valid, out_code, out_err, obs_ready);
      end
    end
    cycle(1'b1, 1'b1, 4'b1000, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_code !== 2'd3 || obs_ready !== 1'b1) begin
      failures++;
      $display("FAIL release: valid=%b code=%0d ready=%b, required 1 3 1",
               out_valid, out_code, obs_ready);
    end
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
  endtask

  task automatic test_errors();
    logic [3:0] words [3];
    logic [1:0] codes [3];
    words = '{4'b0000, 4'b0110, 4'b1111};
    codes = '{2'd0, 2'd2, 2'd3};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, words[i], 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_code !== codes[i] || out_err !== 1'b1) begin
        failures++;
        $display("FAIL err_word_%0d: valid=%b code=%0d err=%b, required 1 %0d 1",
                 i, out_valid, out_code, out_err, codes[i]);
      end
    end
    checks++;
    if (err_count !== 8'd3) begin
      failures++;
      $display("FAIL err_count: got %0d, required 3", err_count);
    end
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) cycle(1'b1, 1'b1, 4'b0000, 1'b1);
    checks++;
    if (err_count !== 8'd255 || m_cnt != 255) begin
      failures++;
      $display("FAIL saturation: got %0d, required 255", err_count);
    end
    cycle(1'b1, 1'b1, 4'b1010, 1'b1);
    checks++;
    if (err_count !== 8'd255) begin
      failures++;
      $display("FAIL saturation_hold: got %0d, required 255", err_count);
    end
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
  endtask

  task automatic test_random();
    logic v, r;
    logic [3:0] w;
    cycle(1'b0, 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      w = ($urandom_range(0, 1) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      cycle(1'b1, v, w, r);
      checks++;
      if (out_valid !== m_valid || out_code !== m_code || out_err !== m_err ||
          err_count !== 8'(m_cnt) || obs_ready !== exp_ready) begin
        failures++;
        $display("FAIL random_%0d: v=%b c=%0d e=%b n=%0d rdy=%b, required %b %0d %b %0d %b",
                 i, out_valid, out_code, out_err, err_count, obs_ready,
                 m_valid, m_code, m_err, m_cnt, exp_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b1, 4'b0000, 1'b1);
    cycle(1'b1, 1'b1, 4'b0010, 1'b0);
    cycle(1'b0, 1'b1, 4'b0100, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || err_count !== 8'd0 || out_code !== 2'd0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b code=%0d err=%b cnt=%0d, required 0 0 0 0",
               out_valid, out_code, out_err, err_count);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    m_valid = 1'b0; m_code = 2'd0; m_err = 1'b0; m_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_onehot = 4'd0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_sweep();
    test_backpressure();
    test_errors();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
